// File: rtl/ctx_sched_pkg.sv
// Shared types and defaults for the dual-context time-slice scheduler.
package ctx_sched_pkg;

    localparam int QUANTUM_W_DEF       = 10;
    localparam int DEFAULT_QUANTUM_DEF = 100;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_OS_RUN,
        ST_TO_PROC,
        ST_PROC_RUN,
        ST_TO_OS
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_EXPIRED = 2'd1,
        CAUSE_SYSCALL = 2'd2,
        CAUSE_EXIT    = 2'd3
    } cause_t;

endpackage

// File: rtl/ctx_sched_ctrl_quantum_counter.sv
// Per-dispatch quantum down-counter; stops at 0 and flags the terminal decrement.
module quantum_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         sat_zero,
    output logic [W-1:0] count,
    output logic         expire
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // sat_zero turns the counter into pure accounting: it still runs down but never expires
    assign expire = en && !sat_zero && (count == W'(1));

endmodule

// File: rtl/ctx_sched_ctrl.sv
// Time-slice scheduler for the OS/process PC pair.
// CTX_PREEMPT_EN: when defined, quantum expiry forces a return to the OS; otherwise scheduling is cooperative.
module ctx_sched_ctrl
    import ctx_sched_pkg::*;
#(
    parameter int QUANTUM_W       = QUANTUM_W_DEF,
    parameter int DEFAULT_QUANTUM = DEFAULT_QUANTUM_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bios_done,
    input  logic                 run_proc_req,
    input  logic [QUANTUM_W-1:0] quantum_in,
    input  logic                 syscall_req,
    input  logic                 proc_exit,
    input  logic                 io_stall,
    output logic                 proc_num,
    output logic                 hlt,
    output logic                 ctx_switch,
    output logic [1:0]           cause,
    output logic [QUANTUM_W-1:0] quantum_left,
    output logic                 busy_proc
);

`ifdef CTX_PREEMPT_EN
    localparam logic PREEMPT = 1'b1;
`else
    localparam logic PREEMPT = 1'b0;
`endif

    state_t                 state;
    cause_t                 cause_q;
    logic                   hold_q;
    logic                   load;
    logic                   dec_en;
    logic                   expire;
    logic [QUANTUM_W-1:0]   load_val;

    assign load     = (state == ST_OS_RUN) && run_proc_req;
    assign load_val = (quantum_in == '0) ? QUANTUM_W'(DEFAULT_QUANTUM) : quantum_in;
    assign dec_en   = (state == ST_PROC_RUN) && !io_stall;

    quantum_counter #(.W(QUANTUM_W)) u_quantum (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (dec_en),
        .sat_zero (!PREEMPT),
        .count    (quantum_left),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_BOOT;
            proc_num   <= 1'b0;
            hold_q     <= 1'b1;
            ctx_switch <= 1'b0;
            cause_q    <= CAUSE_NONE;
            busy_proc  <= 1'b0;
        end else begin
            ctx_switch <= 1'b0;
            unique case (state)
                ST_BOOT: begin
                    if (bios_done) begin
                        state  <= ST_OS_RUN;
                        hold_q <= 1'b0;
                    end
                end
                ST_OS_RUN: begin
                    if (run_proc_req) begin
                        state      <= ST_TO_PROC;
                        hold_q     <= 1'b1;
                        proc_num   <= 1'b1;
                        ctx_switch <= 1'b1;
                        busy_proc  <= 1'b1;
                        cause_q    <= CAUSE_NONE;
                    end
                end
                ST_TO_PROC: begin
                    state  <= ST_PROC_RUN;
                    hold_q <= 1'b0;
                end
                ST_PROC_RUN: begin
                    if (proc_exit || syscall_req || expire) begin
                        state      <= ST_TO_OS;
                        hold_q     <= 1'b1;
                        proc_num   <= 1'b0;
                        ctx_switch <= 1'b1;
                        if (proc_exit) begin
                            cause_q   <= CAUSE_EXIT;
                            busy_proc <= 1'b0;
                        end else if (syscall_req) begin
                            cause_q <= CAUSE_SYSCALL;
                        end else begin
                            cause_q <= CAUSE_EXPIRED;
                        end
                    end
                end
                ST_TO_OS: begin
                    state  <= ST_OS_RUN;
                    hold_q <= 1'b0;
                end
                default: begin
                    state    <= ST_BOOT;
                    hold_q   <= 1'b1;
                    proc_num <= 1'b0;
                end
            endcase
        end
    end

    // Stall must freeze the PC in the same cycle, so it bypasses the registered hold
    assign hlt   = hold_q || io_stall;
    assign cause = cause_q;

endmodule

// File: tb/tb_ctx_sched_ctrl.sv
// Directed bench for ctx_sched_ctrl: cycle table plus hand-written expiry/cooperative sequences.
module tb_ctx_sched_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       bios_done, run_proc_req, syscall_req, proc_exit, io_stall;
    logic [9:0] quantum_in;
    logic       proc_num, hlt, ctx_switch, busy_proc;
    logic [1:0] cause;
    logic [9:0] quantum_left;

    int tests  = 0;
    int failed = 0;

    ctx_sched_ctrl #(.QUANTUM_W(10), .DEFAULT_QUANTUM(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .bios_done    (bios_done),
        .run_proc_req (run_proc_req),
        .quantum_in   (quantum_in),
        .syscall_req  (syscall_req),
        .proc_exit    (proc_exit),
        .io_stall     (io_stall),
        .proc_num     (proc_num),
        .hlt          (hlt),
        .ctx_switch   (ctx_switch),
        .cause        (cause),
        .quantum_left (quantum_left),
        .busy_proc    (busy_proc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, bd, rr;
        logic [9:0] qi;
        logic       sc, ex, st;
        logic       pn, hl, cs;
        logic [1:0] ca;
        logic [9:0] ql;
        logic       bs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, bd, rr, input int qi, input logic sc, ex, st,
                               input logic pn, hl, cs, input int ca, input int ql, input logic bs);
        vec_t x;
        x.rst_n = r;  x.bd = bd;  x.rr = rr;  x.qi = 10'(qi);
        x.sc = sc;    x.ex = ex;  x.st = st;
        x.pn = pn;    x.hl = hl;  x.cs = cs;  x.ca = 2'(ca);  x.ql = 10'(ql);  x.bs = bs;
        return x;
    endfunction

    task automatic drive(input logic r, bd, rr, input int qi, input logic sc, ex, st);
        reset = r; bios_done = bd; run_proc_req = rr; quantum_in = 10'(qi);
        syscall_req = sc; proc_exit = ex; io_stall = st;
    endtask

    task automatic check_out(input string name, input logic e_pn, e_hl, e_cs,
                             input logic [1:0] e_ca, input int e_ql, input logic e_bs);
        tests++;
        if ({proc_num, hlt, ctx_switch, cause, quantum_left, busy_proc} !==
            {e_pn, e_hl, e_cs, e_ca, 10'(e_ql), e_bs}) begin
            failed++;
            $display("FAIL %s: got pn=%0b hlt=%0b cs=%0b cause=%0d ql=%0d busy=%0b, want pn=%0b hlt=%0b cs=%0b cause=%0d ql=%0d busy=%0b",
                     name, proc_num, hlt, ctx_switch, cause, quantum_left, busy_proc,
                     e_pn, e_hl, e_cs, e_ca, e_ql, e_bs);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One cycle: drive at the falling edge, compare just after, the rising edge then consumes the inputs
    task automatic step(input logic bd, rr, input int qi, input logic sc, ex, st);
        @(negedge clk);
        drive(1'b1, bd, rr, qi, sc, ex, st);
        #1;
    endtask

    // Dispatch from OS_RUN and check the OS_RUN and TO_PROC cycles
    task automatic dispatch(input string name, input int qi, input int q_eff, input logic [1:0] prev_cause,
                            input int prev_ql, input logic prev_busy);
        step(0, 1, qi, 0, 0, 0);
        check_out({name, "_os"}, 0, 0, 0, prev_cause, prev_ql, prev_busy);
        step(0, 0, 0, 0, 0, 0);
        check_out({name, "_to_proc"}, 1, 1, 1, 0, q_eff, 1);
    endtask

    initial begin
        //       rst bd rr qi  sc ex st | pn hl cs ca  ql  bs
        vecs.push_back(v(0, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0,   0)); // 2nd reset cycle
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0,   0)); // BOOT
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0,   0));
        vecs.push_back(v(1, 1, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0,   0)); // bios_done
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0,   0)); // OS_RUN
        vecs.push_back(v(1, 0, 0, 0,  1, 1, 0,  0, 0, 0, 0, 0,   0)); // events ignored in OS
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0, 0,   0)); // stall -> hlt
        vecs.push_back(v(1, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0, 0,   0)); // dispatch q=0
        vecs.push_back(v(1, 0, 1, 7,  0, 1, 0,  1, 1, 1, 0, 100, 1)); // TO_PROC, ignores rr/exit
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 100, 1)); // PROC_RUN 1
        vecs.push_back(v(1, 0, 1, 3,  0, 0, 0,  1, 0, 0, 0, 99,  1)); // rr ignored
        vecs.push_back(v(1, 0, 0, 0,  1, 0, 0,  1, 0, 0, 0, 98,  1)); // syscall
        vecs.push_back(v(1, 0, 0, 0,  1, 0, 0,  0, 1, 1, 2, 97,  1)); // TO_OS
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 2, 97,  1)); // OS_RUN, cause held
        vecs.push_back(v(1, 0, 1, 10, 0, 0, 0,  0, 0, 0, 2, 97,  1)); // dispatch q=10
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  1, 1, 1, 0, 10,  1));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 10,  1));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 9,   1));
        vecs.push_back(v(1, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0, 8,   1)); // syscall+exit, exit wins
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 1, 1, 3, 7,   0));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 3, 7,   0));
        vecs.push_back(v(1, 0, 1, 6,  0, 0, 0,  0, 0, 0, 3, 7,   0)); // dispatch q=6
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 1,  1, 1, 1, 0, 6,   1));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 6,   1));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 5,   1)); // stalled, frozen
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 1,  1, 1, 0, 0, 5,   1));
        vecs.push_back(v(1, 0, 0, 0,  1, 0, 1,  1, 1, 0, 0, 5,   1)); // syscall during stall
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 1, 1, 2, 5,   1));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 2, 5,   1));
        vecs.push_back(v(1, 0, 1, 2,  0, 0, 0,  0, 0, 0, 2, 5,   1)); // dispatch q=2
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  1, 1, 1, 0, 2,   1));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 2,   1));
        vecs.push_back(v(0, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 1,   1)); // reset mid-run
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0,   0)); // back in BOOT
        vecs.push_back(v(1, 1, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0,   0));
        vecs.push_back(v(1, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0,   0)); // OS_RUN

        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].bd, vecs[i].rr, int'(vecs[i].qi),
                  vecs[i].sc, vecs[i].ex, vecs[i].st);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].pn, vecs[i].hl, vecs[i].cs,
                      vecs[i].ca, int'(vecs[i].ql), vecs[i].bs);
        end

`ifdef CTX_PREEMPT_EN
        begin
            int n;
            int u;
            int c;
            logic stl;
            dispatch("exp5", 5, 5, 0, 0, 0);
            n = 0;
            for (int k = 0; k < 40; k++) begin
                step(0, 0, 0, 0, 0, 0);
                if (ctx_switch) break;
                check_out($sformatf("exp5_run%0d", n), 1, 0, 0, 0, 5 - n, 1);
                n++;
            end
            check_int("exp5_len", n, 5);
            check_out("exp5_to_os", 0, 1, 1, 1, 0, 1);

            step(0, 0, 0, 0, 0, 0);
            check_out("exp5_os", 0, 0, 0, 1, 0, 1);
            dispatch("stall4", 4, 4, 1, 0, 1);
            u = 0;
            c = 0;
            for (int k = 0; k < 40; k++) begin
                stl = (c >= 1 && c <= 3);
                step(0, 0, 0, 0, 0, stl);
                if (ctx_switch) break;
                check_out($sformatf("stall4_run%0d", c), 1, stl, 0, 0, 4 - u, 1);
                if (!stl) u++;
                c++;
            end
            check_int("stall4_unstalled", u, 4);
            check_int("stall4_cycles", c, 7);
            check_out("stall4_to_os", 0, 1, 1, 1, 0, 1);
        end
`else
        begin
            int exp_ql;
            dispatch("coop3", 3, 3, 0, 0, 0);
            for (int k = 0; k < 8; k++) begin
                exp_ql = (k < 3) ? 3 - k : 0;
                step(0, 0, 0, 0, 0, 0);
                check_out($sformatf("coop3_run%0d", k), 1, 0, 0, 0, exp_ql, 1);
            end
            step(0, 0, 0, 1, 0, 0);
            check_out("coop3_sys", 1, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 0);
            check_out("coop3_to_os", 0, 1, 1, 2, 0, 1);
            step(0, 0, 0, 0, 0, 0);
            check_out("coop3_os", 0, 0, 0, 2, 0, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ctx_sched_ctrl.md
Name: ctx_sched_ctrl

Overview:
- Time-slice scheduler that sequences the dual-context program counter (OS context and process context).
- Drives the context select (proc_num) and freeze (hlt) controls of the PC, and counts a per-dispatch quantum.
- Returns control to the OS on quantum expiry, syscall or process exit, and records the cause for the OS.
- Sits between the control unit / OS-visible registers and the PC.

Parameters:
QUANTUM_W, 10, width of quantum counter and quantum_in/quantum_left.
DEFAULT_QUANTUM, 100, quantum loaded when quantum_in == 0 at dispatch.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
bios_done  in  1  pulse: BIOS boot finished, OS may run
run_proc_req  in  1  pulse from OS: dispatch process context
quantum_in  in  QUANTUM_W  quantum for this dispatch, sampled with run_proc_req
syscall_req  in  1  pulse: process requests OS service
proc_exit  in  1  pulse: process executed terminating halt
io_stall  in  1  level: datapath stall, freeze execution
proc_num  out  1  0 = OS PC selected, 1 = process PC selected
hlt  out  1  PC hold
ctx_switch  out  1  one-cycle pulse on each context change
cause  out  2  last return cause: 0 none, 1 quantum expired, 2 syscall, 3 exit
quantum_left  out  QUANTUM_W  remaining process cycles
busy_proc  out  1  1 while a dispatched process is not yet returned

Behaviour:
- States: BOOT, OS_RUN, TO_PROC, PROC_RUN, TO_OS.
- Reset (reset==0 at clk edge) values:
  - state = BOOT, proc_num = 0, hlt = 1, ctx_switch = 0.
  - cause = 0, quantum_left = 0, busy_proc = 0.
  - Reset overrides everything, including mid-dispatch; the process context is abandoned.
- BOOT: hlt = 1, proc_num = 0. Moves to OS_RUN on bios_done.
- OS_RUN: hlt = io_stall, proc_num = 0.
  - On run_proc_req, load the counter with quantum_in, or DEFAULT_QUANTUM if quantum_in == 0.
  - In the same edge: set busy_proc = 1, cause = 0, and go to TO_PROC.
  - run_proc_req is ignored in every other state.
- TO_PROC (exactly 1 cycle): hlt = 1 (bubble, no PC update), proc_num = 1, ctx_switch = 1. Then go to PROC_RUN.
- PROC_RUN: proc_num = 1, hlt = io_stall.
  - The counter decrements on each cycle with io_stall == 0.
  - Return events, priority highest first:
    - proc_exit: cause = 3, busy_proc = 0.
    - syscall_req: cause = 2, busy_proc stays 1.
    - expiry (counter == 1 and decrementing): cause = 1, busy_proc stays 1.
  - Any return event moves to TO_OS on the next edge.
  - Events are accepted even while io_stall == 1; expiry cannot occur during a stall.
  - Exactly Q unstalled PROC_RUN cycles precede TO_OS on expiry.
- TO_OS (exactly 1 cycle): hlt = 1, proc_num = 0, ctx_switch = 1. Then go to OS_RUN.
- quantum_left mirrors the counter.
  - On syscall or exit it holds the remaining value, so the OS can reuse it on resume.
  - On expiry it reads 0.
- cause holds until the next accepted run_proc_req.
- Event pulses arriving in BOOT, OS_RUN, TO_PROC or TO_OS are ignored.
- Counter arithmetic is unsigned QUANTUM_W-bit, never wraps below 0.

Optional Feature:
- CTX_PREEMPT_EN defined: quantum expiry forces a return to the OS as described above.
- CTX_PREEMPT_EN undefined (cooperative scheduling):
  - Expiry is disabled; the counter saturates at 0 and cause = 1 never occurs.
  - The process returns only on syscall_req or proc_exit.
  - quantum_left still counts down, for accounting.

Decomposition:
- Package ctx_sched_pkg:
  - state enum (BOOT, OS_RUN, TO_PROC, PROC_RUN, TO_OS).
  - cause codes CAUSE_NONE/EXPIRED/SYSCALL/EXIT.
  - Default constants for QUANTUM_W and DEFAULT_QUANTUM.
- Sub-module quantum_counter:
  - Inputs: load, load value, enable (decrement), saturate-at-0.
  - Outputs: count and an expire flag.

Test Plan:
- Reset then boot: reset=0 for 2 cycles, then reset=1 and bios_done pulse → proc_num=0, hlt=1 until bios_done; OS_RUN one cycle later with hlt=0, cause=0.
- Dispatch with quantum_in=5, no stall → TO_PROC 1 cycle (ctx_switch=1, hlt=1); 5 PROC_RUN cycles with proc_num=1; TO_OS pulse; cause=1, quantum_left=0, busy_proc=1.
- Dispatch with quantum_in=0 → quantum_left=100 in the first PROC_RUN cycle.
- Dispatch quantum_in=10, syscall_req at PROC_RUN cycle 3 with proc_exit in the same cycle → cause=3, busy_proc=0, quantum_left=7, back to OS_RUN.
- Dispatch quantum_in=4 with io_stall high for 3 cycles mid-run → hlt=1 during the stall, counter frozen, expiry after 4 unstalled cycles.
- reset=0 asserted during PROC_RUN → next cycle state BOOT, proc_num=0, hlt=1, cause=0, quantum_left=0.
- Build without CTX_PREEMPT_EN, quantum_in=3 → stays in PROC_RUN past 3 cycles with quantum_left=0 until a syscall_req, then cause=2.
